// File: rtl/vec_load_unit_if.sv
// Bus bundle of the vector load unit: execute-stage request, data memory port
// and register-bank vector write port.
interface vec_load_unit_if;
    logic         start;
    logic [31:0]  base_addr;
    logic [1:0]   vd;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_rdata;
    logic         mem_rvalid;
    logic         vwe;
    logic [3:0]   vwa;
    logic [127:0] vwd;
    logic         busy;
    logic         done;
    logic         err;

    // Driver side: execute stage plus data memory.
    modport master (
        output start, base_addr, vd, mem_rdata, mem_rvalid,
        input  mem_req, mem_addr, vwe, vwa, vwd, busy, done, err
    );

    // The load unit itself.
    modport slave (
        input  start, base_addr, vd, mem_rdata, mem_rvalid,
        output mem_req, mem_addr, vwe, vwa, vwd, busy, done, err
    );
endinterface

// File: rtl/vec_load_unit.sv
// Vector load unit: fetches four consecutive 32-bit words and writes them as
// one 128-bit vector into the register bank. All outputs are registered.
module vec_load_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    vec_load_unit_if.slave  bus
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANE_W = 96;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   base_q;
    logic [1:0]          vd_q;
    logic [1:0]          idx_q;
    logic [1:0]          idx_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    // Lanes 0..2 are buffered; lane 3 goes straight from mem_rdata into vwd.
    logic [LANE_W-1:0]   lanes_q;

    logic                mem_req_q;
    logic [WORD_W-1:0]   mem_addr_q;
    logic                vwe_q;
    logic [3:0]          vwa_q;
    logic [127:0]        vwd_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    // Next word index and next wait count.
    always_comb begin
        idx_d = idx_q + 2'd1;
        cnt_d = cnt_q + CNT_W'(1);
    end

    // Load sequencer with registered one-cycle output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            vd_q       <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            lanes_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            vwe_q      <= 1'b0;
            vwa_q      <= '0;
            vwd_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            vwe_q      <= 1'b0;
            vwa_q      <= '0;
            vwd_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.base_addr[1:0] == 2'b00) begin
                            base_q     <= bus.base_addr;
                            vd_q       <= bus.vd;
                            idx_q      <= '0;
                            lanes_q    <= '0;
                            busy_q     <= 1'b1;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= bus.base_addr;
                            state_q    <= REQ;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end

                WAIT: begin
                    if (cnt_q == TIMEOUT_C) begin
                        // err already pulsed; this is the abort cycle.
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        lanes_q <= '0;
                        state_q <= IDLE;
                    end else if (bus.mem_rvalid) begin
                        if (idx_q == 2'd3) begin
                            vwe_q   <= 1'b1;
                            done_q  <= 1'b1;
                            vwa_q   <= {2'b00, vd_q};
                            vwd_q   <= {bus.mem_rdata, lanes_q};
                            state_q <= WRITE;
                        end else begin
                            case (idx_q)
                                2'd0:    lanes_q[31:0]  <= bus.mem_rdata;
                                2'd1:    lanes_q[63:32] <= bus.mem_rdata;
                                default: lanes_q[95:64] <= bus.mem_rdata;
                            endcase
                            idx_q      <= idx_d;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= base_q + {28'd0, idx_d, 2'b00};
                            state_q    <= REQ;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == TIMEOUT_C) begin
                            err_q <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    lanes_q <= '0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Drive the bus from the output registers.
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.vwe      = vwe_q;
    assign bus.vwa      = vwa_q;
    assign bus.vwd      = vwd_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: doc/vec_load_unit.md
# vec_load_unit

Vector load unit feeding the register bank's 128-bit vector write port. On a start pulse it fetches four consecutive 32-bit words from data memory, one request at a time, and assembles them into one 128-bit vector. It then issues a single-cycle vector write (write enable, address, data) into the register bank. It sits between the execute stage, which supplies base address and destination, and the register bank.

## Interface
- TIMEOUT, 255: max cycles to wait for mem_rvalid per word before aborting; 8-bit counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  32  byte address of word 0; must be word-aligned.
- vd  in  2  destination vector register 0..3.
- mem_req  out  1  memory read request, high exactly one cycle per word.
- mem_addr  out  32  read address, valid while mem_req=1, else 0.
- mem_rdata  in  32  read data, valid with mem_rvalid.
- mem_rvalid  in  1  read response strobe.
- vwe  out  1  vector write enable to register bank, one-cycle pulse.
- vwa  out  4  vector write address, {2'b00, vd}; 0 when vwe=0.
- vwd  out  128  assembled vector; 0 when vwe=0.
- busy  out  1  high from the cycle after accepted start through the WRITE or abort cycle.
- done  out  1  one-cycle pulse, coincident with vwe.
- err  out  1  one-cycle pulse on misalignment or timeout.

## Operation
- States: IDLE, REQ, WAIT, WRITE.
- IDLE, start=1, base_addr[1:0]==0:
  - latch base_addr and vd; idx=0; clear lane buffer; go to REQ.
- IDLE, start=1, base_addr[1:0]!=0:
  - err=1 next cycle; no memory request; stay IDLE; busy stays 0.
- REQ: mem_req=1, mem_addr=base+4*idx (32-bit wrap-around, no carry out); clear wait counter; go to WAIT.
- WAIT, mem_rvalid=1:
  - lane[idx] ← mem_rdata; lane i occupies vwd[32i+31:32i].
  - If idx==3, go to WRITE; else idx+1, go to REQ.
- WAIT, no rvalid:
  - Increment wait counter.
  - When the counter reaches TIMEOUT: err=1, no vwe, discard lanes, go to IDLE.
- WRITE: vwe=1, vwa={2'b00,vd}, vwd=lane buffer, done=1; go to IDLE.
- start while busy is ignored; it is not queued.
- mem_rvalid in IDLE, REQ or WRITE is ignored. Memory latency is ≥1 cycle after mem_req.
- rst in any state:
  - Next state IDLE; idx, lanes and counters cleared.
  - Any pending write is dropped.
  - All outputs 0 in the cycle after rst.

## Timing
- Reset values: mem_req=0, mem_addr=0, vwe=0, vwa=0, vwd=0, busy=0, done=0, err=0.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Start sampled at edge t, memory latency L (rvalid L cycles after the mem_req cycle):
  - word k request at t+1+k(L+1)
  - vwe/done at t+1+4(L+1)
- For L=1, requests are at t+1, t+3, t+5, t+7; vwe at t+9; busy high t+1..t+9.
- Next start is accepted at the edge after the WRITE cycle; back-to-back throughput is one load per 4(L+1)+2 cycles.
- Timeout: err is asserted on the cycle the counter hits TIMEOUT, i.e. TIMEOUT cycles after entering WAIT; busy drops the next cycle.

## Test plan
- Basic load:
  - Stimulus: base=0x100, vd=2; memory L=1 returns 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Required: mem_addr 0x100/0x104/0x108/0x10C; vwe at t+9, vwa=4'd2, vwd=0x44444444_33333333_22222222_11111111, done=1.
- Variable latency:
  - Stimulus: L=3 for word 0, L=1 for the others; start ignored while busy.
  - Required: exactly 4 mem_req pulses, one vwe, data ordered by lane; the second start produces no activity.
- Misaligned address:
  - Stimulus: base=0x102.
  - Required: err pulse one cycle after start; mem_req, vwe and busy stay 0.
- Timeout:
  - Stimulus: TIMEOUT=4; memory never responds to word 1.
  - Required: err pulse 4 cycles after word 1's WAIT entry; no vwe; IDLE afterward. A following good load succeeds.
- Reset mid-load:
  - Stimulus: assert rst while in WAIT on word 2, then release.
  - Required: all outputs 0 the next cycle; no vwe ever appears. A late mem_rvalid has no effect; a new start behaves as the basic-load case.
- Address wrap:
  - Stimulus: base=0xFFFFFFF8.
  - Required: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
